// File: rtl/seq_mul_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_mul_pkg;

    // Controller states. FIX is reachable only when the signed build is enabled.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Number of accumulation steps needed to consume the multiplier operand.
    function automatic int steps(input int width, input int digit);
        return width / digit;
    endfunction

    // Step counter width; one spare bit so the last index never wraps.
    function automatic int cnt_width(input int width, input int digit);
        return $clog2(steps(width, digit)) + 1;
    endfunction

endpackage

// File: rtl/seq_mul_controller.sv
// FSM and step counter sequencing the shift-add datapath (macro SEQ_MULTIPLIER_SIGNED_EN adds FIX).
// Latency: STEPS accumulate cycles, then DONE (plus one FIX cycle in the signed build).
// Backpressure: accepts start only in IDLE (ready=1); start elsewhere is dropped, no queueing.
module seq_mul_controller
    import seq_mul_pkg::*;
#(
    parameter int STEPS = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          ready,
    output logic          done,
    output logic          ld,
    output logic          acc_en,
    output logic          fix_en,
    output logic [CW-1:0] cnt
);

    state_t state;
    state_t state_nxt;
    logic   last_step;

    assign last_step = (cnt == CW'(STEPS - 1));

    // State register; synchronous active-low reset returns the block to IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Step counter: cleared on capture, advanced once per accumulate step.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= '0;
        end else if (acc_en) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Next-state and decoded control strobes.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        ld        = 1'b0;
        acc_en    = 1'b0;
        fix_en    = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    ld        = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                acc_en = 1'b1;
                if (last_step) begin
`ifdef SEQ_MULTIPLIER_SIGNED_EN
                    state_nxt = FIX;
`else
                    state_nxt = DONE;
`endif
                end
            end
            FIX: begin
`ifdef SEQ_MULTIPLIER_SIGNED_EN
                fix_en    = 1'b1;
                state_nxt = DONE;
`else
                // Unreachable in the unsigned build; recover to IDLE.
                state_nxt = IDLE;
`endif
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/seq_multiplier.sv
// Parametrised shift-add multiplier, DIGIT multiplier bits per cycle (macro SEQ_MULTIPLIER_SIGNED_EN: two's complement).
// Latency: STEPS+1 cycles from accept edge to done (STEPS+2 in the signed build).
// Backpressure: ready high only in IDLE; start outside IDLE is ignored, product holds until next accept.
module seq_multiplier
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int STEPS = steps(WIDTH, DIGIT);
    localparam int CW    = cnt_width(WIDTH, DIGIT);
    // Shift amount width: cnt*DIGIT with DIGIT <= 4 needs at most 3 extra bits.
    localparam int SW    = CW + 3;

    logic                 ld;
    logic                 acc_en;
    logic                 fix_en;
    logic [CW-1:0]        cnt;

    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     a_in;
    logic [WIDTH-1:0]     b_in;
    logic [SW-1:0]        shamt;
    logic [DIGIT-1:0]     digit;
    logic [2*WIDTH-1:0]   pp;
    logic [2*WIDTH-1:0]   fix_val;

    seq_mul_controller #(
        .STEPS (STEPS),
        .CW    (CW)
    ) u_ctrl (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .ready  (ready),
        .done   (done),
        .ld     (ld),
        .acc_en (acc_en),
        .fix_en (fix_en),
        .cnt    (cnt)
    );

`ifdef SEQ_MULTIPLIER_SIGNED_EN
    logic neg;

    // Magnitudes of the operands; the most negative value maps to 2^(WIDTH-1) unsigned.
    always_comb begin
        a_in = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
        b_in = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    end

    // Result sign remembered from the operands at capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            neg <= 1'b0;
        end else if (ld) begin
            neg <= a[WIDTH-1] ^ b[WIDTH-1];
        end
    end

    // Final sign correction applied in the FIX step.
    always_comb begin
        fix_val = neg ? (~acc + (2*WIDTH)'(1)) : acc;
    end
`else
    // Unsigned build: operands pass straight through and the fix step is a hold.
    always_comb begin
        a_in    = a;
        b_in    = b;
        fix_val = acc;
    end
`endif

    // Operand registers, loaded on the accepting edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_a <= '0;
            op_b <= '0;
        end else if (ld) begin
            op_a <= a_in;
            op_b <= b_in;
        end
    end

    // Digit select and shifted partial product for the current step.
    always_comb begin
        shamt = SW'(cnt) * SW'(DIGIT);
        digit = DIGIT'(op_b >> shamt);
        pp    = ({{WIDTH{1'b0}}, op_a} * (2*WIDTH)'(digit)) << shamt;
    end

    // Accumulator: cleared on capture, summed in CALC, sign-fixed in FIX, held otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
        end else if (ld) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= acc + pp;
        end else if (fix_en) begin
            acc <= fix_val;
        end
    end

    assign product = acc;

endmodule
